// File: rtl/display_scan_controller.sv
// Multiplexed 7-segment scan controller with frame-aligned value update.
// Optional: define LEADING_ZERO_BLANK_EN to darken leading zero digits.
module display_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic                  ready,
  output logic [6:0]            abcdefg,
  output logic [DIGITS-1:0]     digit,
  output logic                  frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [IW-1:0]       idx, idx_n;
  logic [4*DIGITS-1:0] active, active_n;
  logic [4*DIGITS-1:0] shadow, shadow_n;
  logic                pending, pending_n;
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   dig_n;
  logic                fs_n;
  logic                accept;
  logic [3:0]          nib;
  logic [DIGITS-1:0]   sel;
  logic                dark;
`ifdef LEADING_ZERO_BLANK_EN
  logic                zhi;
`endif

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] f;
    unique case (n)
      4'h0: f = 7'b1111110;
      4'h1: f = 7'b0110000;
      4'h2: f = 7'b1101101;
      4'h3: f = 7'b1111001;
      4'h4: f = 7'b0110011;
      4'h5: f = 7'b1011011;
      4'h6: f = 7'b1011111;
      4'h7: f = 7'b1110000;
      4'h8: f = 7'b1111111;
      4'h9: f = 7'b1111011;
      4'hA: f = 7'b1110111;
      4'hB: f = 7'b0011111;
      4'hC: f = 7'b1001110;
      4'hD: f = 7'b0111101;
      4'hE: f = 7'b1001111;
      4'hF: f = 7'b1000111;
    endcase
    return f;
  endfunction

  assign ready  = ~pending;
  assign accept = load & ~pending;

  always_comb begin
    cnt_n     = cnt + 1'b1;
    idx_n     = idx;
    active_n  = active;
    shadow_n  = shadow;
    pending_n = pending;
    seg_n     = '0;
    dig_n     = '0;
    nib       = '0;
    sel       = '0;
    dark      = 1'b0;
    if (cnt == CNT_LAST) begin
      cnt_n = '0;
      idx_n = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
    state_n = (cnt_n < CNT_SHOW) ? BLANK : SHOW;
    // the registered frame_start marks the boundary cycle itself
    if (frame_start) begin
      if (pending) begin
        active_n  = shadow;
        pending_n = 1'b0;
      end else if (accept) begin
        active_n = value;
      end
    end else if (accept) begin
      shadow_n  = value;
      pending_n = 1'b1;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib    = active_n[4*i +: 4];
        sel[i] = 1'b1;
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    zhi = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zhi = zhi & (active_n[4*i +: 4] == 4'h0);
      if (idx == IW'(i) && zhi)
        dark = 1'b1;
    end
`endif
    fs_n = (cnt == '0) && (idx == '0);
    if (state == SHOW && !dark) begin
      seg_n = font(nib);
      dig_n = sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= '0;
      active      <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      abcdefg     <= '0;
      digit       <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      active      <= active_n;
      shadow      <= shadow_n;
      pending     <= pending_n;
      abcdefg     <= seg_n;
      digit       <= dig_n;
      frame_start <= fs_n;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller (DIGITS=4, REFRESH_DIV=8, BLANK=2).
module tb_display_scan_controller;

  localparam int FRAME = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        ready;
  logic [6:0]  abcdefg;
  logic [3:0]  digit;
  logic        frame_start;

  int total = 0;
  int bad   = 0;
  int pos   = 0;

  display_scan_controller #(
    .DIGITS(4),
    .REFRESH_DIV(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .value(value),
    .ready(ready),
    .abcdefg(abcdefg),
    .digit(digit),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  function automatic logic lit(input logic [15:0] v, input int p);
    int slot = p / 8;
    if ((p % 8) < 2) return 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0 && (v >> (4 * slot)) == 16'h0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int p);
    int slot = p / 8;
    if (!lit(v, p)) return 7'b0;
    return font(v[4*slot +: 4]);
  endfunction

  function automatic logic [3:0] exp_dig(input logic [15:0] v, input int p);
    int slot = p / 8;
    if (!lit(v, p)) return 4'b0;
    return 4'b0001 << slot;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    pos = (pos + 1) % FRAME;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (abcdefg !== 7'b0 || digit !== 4'b0 || frame_start !== 1'b0) begin
      bad++;
      $display("FAIL rst_out seg=%b dig=%b fs=%b exp all zero", abcdefg, digit, frame_start);
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready got=%b exp=1", ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    pos = 0;
    total++;
    if (frame_start !== 1'b1 || digit !== 4'b0 || abcdefg !== 7'b0) begin
      bad++;
      $display("FAIL first_cycle fs=%b dig=%b seg=%b exp 1/0/0", frame_start, digit, abcdefg);
    end
    step();
    total++;
    if (frame_start !== 1'b0) begin
      bad++;
      $display("FAIL fs_pulse got=%b exp=0", frame_start);
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 2 * FRAME; k++) begin
      total++;
      if (frame_start !== (pos == 0)) begin
        bad++;
        $display("FAIL idle_fs pos=%0d got=%b", pos, frame_start);
      end
      total++;
      if (digit !== exp_dig(16'h0, pos) || abcdefg !== exp_seg(16'h0, pos)) begin
        bad++;
        $display("FAIL idle_disp pos=%0d dig=%b seg=%b exp %b %b", pos, digit, abcdefg,
                 exp_dig(16'h0, pos), exp_seg(16'h0, pos));
      end
      step();
    end
  endtask

  task automatic test_load();
    for (int k = 0; k < FRAME && pos != 10; k++) step();
    value = 16'h12AF;
    load  = 1'b1;
    step();
    load  = 1'b0;
    value = 16'h0;
    for (int k = 0; k < FRAME && pos != 0; k++) begin
      total++;
      if (ready !== 1'b0 || abcdefg !== exp_seg(16'h0, pos)) begin
        bad++;
        $display("FAIL load_wait pos=%0d ready=%b seg=%b exp 0 %b", pos, ready, abcdefg,
                 exp_seg(16'h0, pos));
      end
      step();
    end
    total++;
    if (frame_start !== 1'b1 || ready !== 1'b0) begin
      bad++;
      $display("FAIL load_boundary fs=%b ready=%b exp 1 0", frame_start, ready);
    end
    step();
    for (int k = 1; k < FRAME; k++) begin
      total++;
      if (ready !== 1'b1 || digit !== exp_dig(16'h12AF, pos) ||
          abcdefg !== exp_seg(16'h12AF, pos)) begin
        bad++;
        $display("FAIL load_show pos=%0d ready=%b dig=%b seg=%b", pos, ready, digit, abcdefg);
      end
      if (pos == 2) begin
        total++;
        if (abcdefg !== 7'b1000111 || digit !== 4'b0001) begin
          bad++;
          $display("FAIL load_d0 seg=%b dig=%b exp 1000111 0001", abcdefg, digit);
        end
      end
      if (pos == 26) begin
        total++;
        if (abcdefg !== 7'b0110000 || digit !== 4'b1000) begin
          bad++;
          $display("FAIL load_d3 seg=%b dig=%b exp 0110000 1000", abcdefg, digit);
        end
      end
      step();
    end
  endtask

  task automatic test_ignore();
    for (int k = 0; k < FRAME && pos != 5; k++) step();
    value = 16'h3C5E;
    load  = 1'b1;
    step();
    load  = 1'b0;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL ign_ready got=%b exp=0", ready);
    end
    for (int k = 0; k < FRAME && pos != 12; k++) step();
    value = 16'hFFFF;
    load  = 1'b1;
    step();
    load  = 1'b0;
    value = 16'h0;
    for (int k = 0; k < FRAME && pos != 0; k++) begin
      total++;
      if (ready !== 1'b0 || abcdefg !== exp_seg(16'h12AF, pos)) begin
        bad++;
        $display("FAIL ign_wait pos=%0d ready=%b seg=%b", pos, ready, abcdefg);
      end
      step();
    end
    step();
    for (int k = 1; k < FRAME; k++) begin
      total++;
      if (ready !== 1'b1 || digit !== exp_dig(16'h3C5E, pos) ||
          abcdefg !== exp_seg(16'h3C5E, pos)) begin
        bad++;
        $display("FAIL ign_show pos=%0d ready=%b dig=%b seg=%b", pos, ready, digit, abcdefg);
      end
      if (pos == 2) begin
        total++;
        if (abcdefg !== 7'b1001111) begin
          bad++;
          $display("FAIL ign_d0 seg=%b exp 1001111", abcdefg);
        end
      end
      step();
    end
  endtask

  task automatic bypass_frame(input logic [15:0] v);
    total++;
    if (frame_start !== 1'b1 || ready !== 1'b1) begin
      bad++;
      $display("FAIL byp_boundary fs=%b ready=%b exp 1 1", frame_start, ready);
    end
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
    value = 16'h0;
  endtask

  task automatic test_boundary_load();
    bypass_frame(16'h0008);
    for (int k = 1; k < FRAME; k++) begin
      total++;
      if (ready !== 1'b1 || digit !== exp_dig(16'h0008, pos) ||
          abcdefg !== exp_seg(16'h0008, pos)) begin
        bad++;
        $display("FAIL byp_show pos=%0d ready=%b dig=%b seg=%b", pos, ready, digit, abcdefg);
      end
      if (pos == 2) begin
        total++;
        if (abcdefg !== 7'b1111111 || digit !== 4'b0001) begin
          bad++;
          $display("FAIL byp_d0 seg=%b dig=%b exp 1111111 0001", abcdefg, digit);
        end
      end
      step();
    end
  endtask

  task automatic test_lzb();
    bypass_frame(16'h0040);
    for (int k = 1; k < FRAME; k++) begin
      total++;
      if (digit !== exp_dig(16'h0040, pos) || abcdefg !== exp_seg(16'h0040, pos)) begin
        bad++;
        $display("FAIL lzb_show pos=%0d dig=%b seg=%b", pos, digit, abcdefg);
      end
      if (pos == 10) begin
        total++;
        if (abcdefg !== 7'b0110011 || digit !== 4'b0010) begin
          bad++;
          $display("FAIL lzb_d1 seg=%b dig=%b exp 0110011 0010", abcdefg, digit);
        end
      end
      if (pos == 26) begin
        total++;
`ifdef LEADING_ZERO_BLANK_EN
        if (abcdefg !== 7'b0 || digit !== 4'b0) begin
          bad++;
          $display("FAIL lzb_d3 seg=%b dig=%b exp dark", abcdefg, digit);
        end
`else
        if (abcdefg !== 7'b1111110 || digit !== 4'b1000) begin
          bad++;
          $display("FAIL lzb_d3 seg=%b dig=%b exp 1111110 1000", abcdefg, digit);
        end
`endif
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < FRAME && pos != 3; k++) step();
    value = 16'h5555;
    load  = 1'b1;
    step();
    load  = 1'b0;
    value = 16'h0;
    for (int k = 0; k < FRAME && pos != 20; k++) step();
    total++;
    if (ready !== 1'b0 || digit !== exp_dig(16'h0040, pos)) begin
      bad++;
      $display("FAIL rmid_pre ready=%b dig=%b", ready, digit);
    end
    reset = 1'b1;
    #1;
    total++;
    if (digit !== 4'b0 || abcdefg !== 7'b0 || frame_start !== 1'b0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL rmid_async dig=%b seg=%b fs=%b ready=%b", digit, abcdefg, frame_start, ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    pos = 0;
    for (int k = 0; k < FRAME; k++) begin
      total++;
      if (ready !== 1'b1 || frame_start !== (pos == 0) ||
          digit !== exp_dig(16'h0, pos) || abcdefg !== exp_seg(16'h0, pos)) begin
        bad++;
        $display("FAIL rmid_after pos=%0d ready=%b fs=%b dig=%b seg=%b", pos, ready,
                 frame_start, digit, abcdefg);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load();
    test_ignore();
    test_boundary_load();
    test_lzb();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
